// File: rtl/adc_avg_comp_if.sv
// adc_avg_comp_if - signal bundle between the SWIPT control side and the
// averaging ADC comparator.
//   master : drives swiptAlive, ADC, th_low, th_high; observes the results
//   slave  : the comparator; observes the inputs, drives adc_comp, adc_mean,
//            mean_valid and measure_adc
// Parameter ADC_W must match the ADC_W of the comparator it is attached to.
interface adc_avg_comp_if #(
    parameter int ADC_W = 12
) ();
    logic             swiptAlive;
    logic [ADC_W-1:0] ADC;
    logic [ADC_W-1:0] th_low;
    logic [ADC_W-1:0] th_high;
    logic             adc_comp;
    logic [ADC_W-1:0] adc_mean;
    logic             mean_valid;
    logic             measure_adc;

    modport master (
        output swiptAlive, ADC, th_low, th_high,
        input  adc_comp, adc_mean, mean_valid, measure_adc
    );

    modport slave (
        input  swiptAlive, ADC, th_low, th_high,
        output adc_comp, adc_mean, mean_valid, measure_adc
    );
endinterface

// File: rtl/adc_avg_comp.sv
// adc_avg_comp - averaging hysteresis comparator for the SWIPT receive path.
// Registers the ADC word every active cycle, takes one sample every PERIOD
// cycles, discards SETTLE samples after enable, averages 2^AVG_LOG2 samples
// and compares the mean against the th_low/th_high hysteresis window.
// Ports:
//   clk   : system clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : adc_avg_comp_if.slave
//           in : swiptAlive (sync enable), ADC, th_low, th_high
//           out: adc_comp, adc_mean, mean_valid (pulse), measure_adc (pulse)
module adc_avg_comp #(
    parameter int ADC_W    = 12,
    parameter int PERIOD   = 401,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 1
) (
    input  logic             clk,
    input  logic             nrst,
    adc_avg_comp_if.slave    bus
);
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam int ACC_W  = ADC_W + AVG_LOG2;

    localparam logic [CNT_W-1:0]  CNT_RELOAD  = CNT_W'(PERIOD - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST   = SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [3:0]         settle_reg;
    logic [SCNT_W-1:0]  scnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ADC_W-1:0]   adc_reg;
    logic [ADC_W-1:0]   mean_reg;
    logic               comp_reg;
    logic               valid_reg;
    logic               measure_reg;

    logic               strobe;
    logic [ACC_W-1:0]   sum;
    logic [ADC_W-1:0]   mean;

    // The counter runs only outside IDLE, so a zero count there is the strobe.
    assign strobe = (state_reg != ST_IDLE) && (cnt_reg == '0);

    // Final sample is folded in directly so the mean is ready on its strobe.
    assign sum  = acc_reg + ACC_W'(adc_reg);
    assign mean = ADC_W'(sum >> AVG_LOG2);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!bus.swiptAlive) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                ST_SETTLE: if (strobe && settle_reg == SETTLE_LAST) state_next = ST_RUN;
                ST_RUN:    state_next = ST_RUN;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_reg     <= '0;
            settle_reg  <= '0;
            scnt_reg    <= '0;
            acc_reg     <= '0;
            adc_reg     <= '0;
            mean_reg    <= '0;
            comp_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            measure_reg <= 1'b0;
        end else if (!bus.swiptAlive) begin
            // Disable discards any partial average and returns to idle values.
            cnt_reg     <= '0;
            settle_reg  <= '0;
            scnt_reg    <= '0;
            acc_reg     <= '0;
            adc_reg     <= '0;
            mean_reg    <= '0;
            comp_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            measure_reg <= 1'b0;
        end else begin
            adc_reg     <= bus.ADC;
            measure_reg <= strobe;
            valid_reg   <= 1'b0;
            if (state_reg == ST_IDLE) begin
                // Edge E0: the first strobe lands PERIOD edges later.
                cnt_reg    <= CNT_RELOAD;
                settle_reg <= '0;
                scnt_reg   <= '0;
                acc_reg    <= '0;
            end else begin
                cnt_reg <= (cnt_reg == '0) ? CNT_RELOAD : cnt_reg - 1'b1;
                if (strobe) begin
                    if (state_reg == ST_SETTLE) begin
                        settle_reg <= settle_reg + 1'b1;
                    end else if (scnt_reg == SCNT_LAST) begin
                        mean_reg  <= mean;
                        valid_reg <= 1'b1;
                        acc_reg   <= '0;
                        scnt_reg  <= '0;
                        // Low check wins, so an inverted window resolves to 1.
                        if (mean < bus.th_low) begin
                            comp_reg <= 1'b1;
                        end else if (mean > bus.th_high) begin
                            comp_reg <= 1'b0;
                        end
                    end else begin
                        acc_reg  <= sum;
                        scnt_reg <= scnt_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.adc_comp    = comp_reg;
    assign bus.adc_mean    = mean_reg;
    assign bus.mean_valid  = valid_reg;
    assign bus.measure_adc = measure_reg;
endmodule

// File: tb/tb_adc_avg_comp.sv
// tb_adc_avg_comp - directed self-checking bench for adc_avg_comp with
// PERIOD=4, AVG_LOG2=2, SETTLE=1.
module tb_adc_avg_comp;
    localparam int ADC_W  = 12;
    localparam int PERIOD = 4;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;
    int   n;

    adc_avg_comp_if #(.ADC_W(ADC_W)) bus ();

    adc_avg_comp #(
        .ADC_W(ADC_W),
        .PERIOD(PERIOD),
        .AVG_LOG2(2),
        .SETTLE(1)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges until measure_adc is seen high (sampled 1 time unit after
    // each rising edge); bounded so a dead strobe cannot hang the run.
    task automatic wait_measure(output int cnt);
        bit found;
        found = 1'b0;
        cnt   = 0;
        for (int i = 1; i <= 64 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.measure_adc === 1'b1) begin
                found = 1'b1;
                cnt   = i;
            end
        end
        if (!found) check_eq("measure_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_comp"},    32'(bus.adc_comp),    32'd0);
        check_eq({tag, "_mean"},    32'(bus.adc_mean),    32'd0);
        check_eq({tag, "_valid"},   32'(bus.mean_valid),  32'd0);
        check_eq({tag, "_measure"}, 32'(bus.measure_adc), 32'd0);
    endtask

    // One full average of a constant ADC value, started right after a mean.
    task automatic do_avg(input string tag, input logic [11:0] v, input logic exp_comp);
        int cnt;
        bus.ADC = v;
        for (int k = 0; k < 4; k++) begin
            wait_measure(cnt);
            check_eq({tag, "_period"}, 32'(cnt), 32'd4);
            if (k < 3) begin
                check_eq({tag, "_valid_early"}, 32'(bus.mean_valid), 32'd0);
            end
        end
        check_eq({tag, "_valid"}, 32'(bus.mean_valid), 32'd1);
        check_eq({tag, "_mean"},  32'(bus.adc_mean),   32'(v));
        check_eq({tag, "_comp"},  32'(bus.adc_comp),   32'(exp_comp));
        $display("avg %s: adc=%h mean=%h comp=%b", tag, v, bus.adc_mean, bus.adc_comp);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset defaults
        nrst           = 1'b0;
        bus.swiptAlive = 1'b1;
        bus.ADC        = 12'hFFF;
        bus.th_low     = 12'h800;
        bus.th_high    = 12'h7FF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_idle("reset");

        // Averaging: 0x100 (settle), 0x100, 0x200, 0x300, 0x401 -> 0x280
        @(negedge clk);
        nrst    = 1'b1;
        bus.ADC = 12'h100;
        wait_measure(n);
        check_eq("first_strobe", 32'(n), 32'(PERIOD + 1));
        check_eq("settle_valid", 32'(bus.mean_valid), 32'd0);
        bus.ADC = 12'h100;
        wait_measure(n);
        check_eq("avg_s2_period", 32'(n), 32'd4);
        check_eq("avg_s2_valid", 32'(bus.mean_valid), 32'd0);
        bus.ADC = 12'h200;
        wait_measure(n);
        check_eq("avg_s3_valid", 32'(bus.mean_valid), 32'd0);
        bus.ADC = 12'h300;
        wait_measure(n);
        check_eq("avg_s4_valid", 32'(bus.mean_valid), 32'd0);
        bus.ADC = 12'h401;
        wait_measure(n);
        check_eq("avg_s5_period", 32'(n), 32'd4);
        check_eq("avg_valid", 32'(bus.mean_valid), 32'd1);
        check_eq("avg_mean",  32'(bus.adc_mean),   32'h280);
        check_eq("avg_comp",  32'(bus.adc_comp),   32'd1);
        $display("avg seq: mean=%h comp=%b", bus.adc_mean, bus.adc_comp);

        // Hysteresis window 0x600..0xA00
        bus.th_low  = 12'h600;
        bus.th_high = 12'hA00;
        do_avg("hys_500", 12'h500, 1'b1);
        do_avg("hys_800a", 12'h800, 1'b1);
        do_avg("hys_B00", 12'hB00, 1'b0);
        do_avg("hys_800b", 12'h800, 1'b0);
        do_avg("hys_A00", 12'hA00, 1'b0);
        do_avg("hys_5FF", 12'h5FF, 1'b1);
        do_avg("hys_600", 12'h600, 1'b1);

        // Legacy single threshold
        bus.th_low  = 12'h800;
        bus.th_high = 12'h7FF;
        do_avg("leg_800a", 12'h800, 1'b0);
        do_avg("leg_7FF", 12'h7FF, 1'b1);
        do_avg("leg_800b", 12'h800, 1'b0);

        // Inverted window resolves to 1
        bus.th_low  = 12'h900;
        bus.th_high = 12'h100;
        do_avg("inv_500", 12'h500, 1'b1);

        // Mid-average drop after two RUN samples
        bus.ADC = 12'h700;
        wait_measure(n);
        wait_measure(n);
        bus.swiptAlive = 1'b0;
        @(posedge clk);
        #1;
        check_idle("drop");
        bus.swiptAlive = 1'b1;
        bus.ADC        = 12'h040;
        bus.th_low     = 12'h600;
        bus.th_high    = 12'hA00;
        wait_measure(n);
        check_eq("drop_first_strobe", 32'(n), 32'(PERIOD + 1));
        for (int k = 2; k <= 5; k++) begin
            wait_measure(n);
            check_eq("drop_period", 32'(n), 32'd4);
            if (k < 5) check_eq("drop_valid_early", 32'(bus.mean_valid), 32'd0);
        end
        check_eq("drop_valid", 32'(bus.mean_valid), 32'd1);
        check_eq("drop_mean",  32'(bus.adc_mean),   32'h040);
        check_eq("drop_comp",  32'(bus.adc_comp),   32'd1);
        $display("avg drop: mean=%h comp=%b", bus.adc_mean, bus.adc_comp);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        check_idle("async");
        @(negedge clk);
        nrst = 1'b1;
        wait_measure(n);
        check_eq("async_first_strobe", 32'(n), 32'(PERIOD + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
